// File: rtl/sd_pkg.sv
// Shared constants and types for the SPI-mode SD sender/receiver pair.
// Frame geometry, start token, CRC polynomials, send_type encodings, FSM states.
package sd_pkg;

   localparam int unsigned CmdFrameLen  = 48;
   localparam int unsigned DataFrameLen = 4120;
   localparam int unsigned CmdPrefixLen = 40;           // bits covered by CRC7
   localparam int unsigned PayloadBits  = 4096;
   localparam int unsigned ShiftWidth   = 8 + PayloadBits; // token + payload
   localparam int unsigned CountWidth   = 13;

   localparam logic [7:0]  START_TOKEN = 8'hFE;
   localparam logic [6:0]  CRC7_POLY   = 7'h09;   // x^7 + x^3 + 1
   localparam logic [15:0] CRC16_POLY  = 16'h1021; // x^16 + x^12 + x^5 + 1

   localparam logic SEND_CMD  = 1'b0;
   localparam logic SEND_DATA = 1'b1;

   localparam logic [CountWidth-1:0] CMD_LAST  = 13'(CmdFrameLen - 1);
   localparam logic [CountWidth-1:0] DATA_LAST = 13'(DataFrameLen - 1);

   typedef enum logic {
      Idle = 1'b0,
      Send = 1'b1
   } sender_state_t;

   // One serial step of the CRC7 LFSR.
   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc16_lfsr.sv
// Serial CRC16-CCITT LFSR (init 0). Clear wins over enable, enable over shift_out.
// shift_out emits the register MSB first with no feedback; crc_bit is the current MSB.
module sd_crc16_lfsr
   import sd_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic shift_out,
   input  logic data_in,
   output logic crc_bit
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;
   logic        fb;

   // Next-state: clear, feed one bit, or shift the result out.
   always_comb begin
      crc_d = crc_q;
      fb    = data_in ^ crc_q[15];
      if (clear) begin
         crc_d = '0;
      end else if (enable) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end else if (shift_out) begin
         crc_d = {crc_q[14:0], 1'b0};
      end
   end

   // CRC state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_bit = crc_q[15];

endmodule

// File: rtl/sync_parallel_counter.sv
// Down counter with synchronous parallel load; decrement saturates at zero.
module sync_parallel_counter #(
   parameter int unsigned Width = 13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [Width-1:0] load_value,
   input  logic             dec,
   output logic [Width-1:0] count
);

   // Load has priority over decrement; never wraps below zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/sd_sender.sv
// SPI-mode SD transmitter: serialises 48-bit command frames (CRC7) and single
// 4120-bit data block frames (token, payload, CRC16), MSB first, one bit per clock.
// Build option SD_SENDER_CRC16_EN: compute the data CRC16; otherwise send 16'hFFFF.
module sd_sender
   import sd_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          send_type,
   input  logic [5:0]    cmd_index,
   input  logic [31:0]   cmd_argument,
   input  logic [4095:0] data_block,
   input  logic          send_valid,
   output logic          send_ready,
   output logic          mosi
);

   sender_state_t            state_q, state_d;
   logic                     type_q;
   logic [ShiftWidth-1:0]    shift_q;
   logic [6:0]               crc7_q;
   logic [CountWidth-1:0]    count;
   logic                     accept;
   logic                     sending;
   logic                     cmd_prefix;
   logic                     cmd_crc;
   logic                     data_prefix;
   logic                     data_crc;
   logic                     crc16_bit;
   logic                     bit_out;

   assign sending = (state_q == Send);
   assign accept  = send_valid && (state_q == Idle);

   // Remaining-bit counter: loaded with frame_len-1 on accept, counts down per bit.
   sync_parallel_counter #(
      .Width (CountWidth)
   ) u_bit_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (accept),
      .load_value ((send_type == SEND_DATA) ? DATA_LAST : CMD_LAST),
      .dec        (sending),
      .count      (count)
   );

   // Frame phase decode from the remaining-bit count.
   always_comb begin
      cmd_prefix  = 1'b0;
      cmd_crc     = 1'b0;
      data_prefix = 1'b0;
      data_crc    = 1'b0;
      if (type_q == SEND_CMD) begin
         cmd_prefix = (count >= 13'd8);
         cmd_crc    = (count >= 13'd1) && (count <= 13'd7);
      end else begin
         data_prefix = (count >= 13'd16);
         data_crc    = (count <= 13'd15);
      end
   end

`ifdef SD_SENDER_CRC16_EN
   logic payload;

   // Payload window excludes the 8 token bits at the head of the frame.
   assign payload = data_prefix && (count <= 13'd4111);

   sd_crc16_lfsr u_crc16 (
      .clock     (clock),
      .reset     (reset),
      .clear     (accept),
      .enable    (sending && payload),
      .shift_out (sending && data_crc),
      .data_in   (shift_q[ShiftWidth-1]),
      .crc_bit   (crc16_bit)
   );
`else
   // CRC16 not built; SPI mode ignores data CRC unless CMD59 enables checking.
   assign crc16_bit = 1'b1;
`endif

   // Serial bit selection; the final command bit is the fixed end bit.
   always_comb begin
      bit_out = 1'b1;
      if (cmd_prefix || data_prefix) begin
         bit_out = shift_q[ShiftWidth-1];
      end else if (cmd_crc) begin
         bit_out = crc7_q[6];
      end else if (data_crc) begin
         bit_out = crc16_bit;
      end
   end

   // Line idles high; in Send it carries the current frame bit.
   always_comb begin
      mosi       = sending ? bit_out : 1'b1;
      send_ready = (state_q == Idle);
   end

   // Next-state: Idle -> Send on request, Send -> Idle after the last bit.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         Idle:    if (send_valid) state_d = Send;
         Send:    if (count == '0) state_d = Idle;
         default: state_d = Idle;
      endcase
   end

   // State and frame-type registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= Idle;
         type_q  <= SEND_CMD;
      end else begin
         state_q <= state_d;
         if (accept) begin
            type_q <= send_type;
         end
      end
   end

   // Shift register: command frames are left-aligned so both types emit from the MSB.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
      end else if (accept) begin
         if (send_type == SEND_DATA) begin
            shift_q <= {START_TOKEN, data_block};
         end else begin
            shift_q <= {2'b01, cmd_index, cmd_argument, {(ShiftWidth - CmdPrefixLen){1'b0}}};
         end
      end else if (sending) begin
         shift_q <= {shift_q[ShiftWidth-2:0], 1'b0};
      end
   end

   // CRC7 accumulates over the first 40 bits, then is shifted out frozen.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         crc7_q <= '0;
      end else if (accept) begin
         crc7_q <= '0;
      end else if (sending && cmd_prefix) begin
         crc7_q <= crc7_next(crc7_q, shift_q[ShiftWidth-1]);
      end else if (sending && cmd_crc) begin
         crc7_q <= {crc7_q[5:0], 1'b0};
      end
   end

endmodule

// File: tb/tb_sd_sender.sv
// Scoreboard bench for sd_sender: stimulus pushes expected frames, a monitor
// captures each mosi frame (send_ready low window) and compares on frame end.
module tb_sd_sender;

   logic          clock;
   logic          reset;
   logic          send_type;
   logic [5:0]    cmd_index;
   logic [31:0]   cmd_argument;
   logic [4095:0] data_block;
   logic          send_valid;
   logic          send_ready;
   logic          mosi;

   int checks = 0;
   int errors = 0;

   logic [4119:0] exp_q[$];
   int            len_q[$];

   sd_sender dut (
      .clock        (clock),
      .reset        (reset),
      .send_type    (send_type),
      .cmd_index    (cmd_index),
      .cmd_argument (cmd_argument),
      .data_block   (data_block),
      .send_valid   (send_valid),
      .send_ready   (send_ready),
      .mosi         (mosi)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

`ifdef SD_SENDER_CRC16_EN
   localparam logic [15:0] CRC_FF = 16'h7FA1;
   localparam logic [15:0] CRC_00 = 16'h0000;
`else
   localparam logic [15:0] CRC_FF = 16'hFFFF;
   localparam logic [15:0] CRC_00 = 16'hFFFF;
`endif

   // Monitor: collect bits while a frame is on the wire, compare when it ends.
   logic [4119:0] cur;
   int            cur_len = 0;
   always @(negedge clock) begin
      logic [4119:0] exp;
      int            elen;
      if (reset) begin
         cur_len = 0;
      end else if (!send_ready) begin
         cur     = {cur[4118:0], mosi};
         cur_len = cur_len + 1;
      end else if (cur_len > 0) begin
         checks++;
         if (mosi !== 1'b1) begin
            errors++;
            $display("FAIL idle_high: mosi=%b required 1", mosi);
         end
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0d bits, required none", cur_len);
         end else begin
            exp  = exp_q.pop_front();
            elen = len_q.pop_front();
            checks++;
            if (cur_len != elen) begin
               errors++;
               $display("FAIL frame_len: got %0d required %0d", cur_len, elen);
            end
            if (elen < 4120) cur = cur & ((4120'(1) << elen) - 4120'(1));
            checks++;
            if (cur !== exp) begin
               errors++;
               $display("FAIL frame_bits: %0d bits differ, tail got %h required %h",
                        $countones(cur ^ exp), cur[47:0], exp[47:0]);
            end
         end
         cur_len = 0;
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clock);
      while (!send_ready && n < 5000) begin
         @(negedge clock);
         n++;
      end
      if (!send_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: send_ready=0 required 1");
      end
   endtask

   // Issue one request at a negedge while ready; accepted on the next posedge.
   task automatic issue(input logic typ, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [4095:0] blk, input logic [4119:0] exp, input int len,
                        input bit push);
      wait_ready();
      send_type    = typ;
      cmd_index    = idx;
      cmd_argument = arg;
      data_block   = blk;
      send_valid   = 1'b1;
      if (push) begin
         exp_q.push_back(exp);
         len_q.push_back(len);
      end
      @(posedge clock);
      #1 send_valid = 1'b0;
   endtask

   localparam logic [47:0] CMD0_F = 48'h40_0000_0000_95;
   localparam logic [47:0] CMD8_F = 48'h48_0000_01AA_87;

   initial begin
      int gap;
      int n;
      reset        = 1'b1;
      send_type    = 1'b0;
      cmd_index    = '0;
      cmd_argument = '0;
      data_block   = '0;
      send_valid   = 1'b0;
      #12;
      checks++;
      if (send_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b required 1", send_ready);
      end
      checks++;
      if (mosi !== 1'b1) begin
         errors++;
         $display("FAIL reset_mosi: got %b required 1", mosi);
      end
      #1 reset = 1'b0;

      issue(1'b0, 6'd0, 32'h0, '0, 4120'(CMD0_F), 48, 1'b1);
      issue(1'b0, 6'd8, 32'h0000_01AA, '0, 4120'(CMD8_F), 48, 1'b1);
      issue(1'b1, 6'd0, 32'h0, {4096{1'b1}}, {8'hFE, {4096{1'b1}}, CRC_FF}, 4120, 1'b1);
      issue(1'b1, 6'd0, 32'h0, '0, {8'hFE, 4096'b0, CRC_00}, 4120, 1'b1);

      // Back-to-back with valid held high; inputs changed mid-frame.
      wait_ready();
      send_type    = 1'b0;
      cmd_index    = 6'd8;
      cmd_argument = 32'h0000_01AA;
      send_valid   = 1'b1;
      exp_q.push_back(4120'(CMD8_F));
      len_q.push_back(48);
      @(posedge clock);
      repeat (10) @(posedge clock);
      #1;
      cmd_index    = 6'd0;
      cmd_argument = 32'h0;
      exp_q.push_back(4120'(CMD0_F));
      len_q.push_back(48);
      wait_ready();
      gap = 0;
      while (send_ready && gap < 10) begin
         gap++;
         @(negedge clock);
      end
      send_valid = 1'b0;
      checks++;
      if (gap != 1) begin
         errors++;
         $display("FAIL b2b_gap: got %0d idle cycles required 1", gap);
      end

      // Abort a command at bit 20 with an asynchronous reset.
      issue(1'b0, 6'd0, 32'h0, '0, '0, 48, 1'b0);
      repeat (20) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (mosi !== 1'b1) begin
         errors++;
         $display("FAIL abort_mosi: got %b required 1", mosi);
      end
      checks++;
      if (send_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready: got %b required 1", send_ready);
      end
      @(negedge clock);
      #3 reset = 1'b0;
      issue(1'b0, 6'd0, 32'h0, '0, 4120'(CMD0_F), 48, 1'b1);

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d frames outstanding required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
